// File: rtl/user_addr_demux.sv
// Address demultiplexer from one request/grant manager port onto NumRules subordinate ports.
// Unmapped addresses go to an internal error subordinate. Responses follow the last target.
module user_addr_demux #(
  parameter int unsigned NumRules  = 2,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 1,
  parameter int unsigned MaxTrans  = 2,
  parameter logic [DataWidth-1:0] ErrData = 32'hBADCAB1E,
  parameter logic [AddrWidth-1:0] RuleStart [NumRules] = '{32'h2000_0000, 32'h2000_1000},
  parameter logic [AddrWidth-1:0] RuleEnd   [NumRules] = '{32'h2000_1000, 32'h2000_2000},
  parameter int unsigned RuleIdx [NumRules] = '{1, 2}
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          mgr_req_i,
  output logic                          mgr_gnt_o,
  input  logic [AddrWidth-1:0]          mgr_addr_i,
  input  logic                          mgr_we_i,
  input  logic [DataWidth/8-1:0]        mgr_be_i,
  input  logic [DataWidth-1:0]          mgr_wdata_i,
  input  logic [IdWidth-1:0]            mgr_aid_i,
  output logic                          mgr_rvalid_o,
  output logic [DataWidth-1:0]          mgr_rdata_o,
  output logic                          mgr_err_o,
  output logic [IdWidth-1:0]            mgr_rid_o,
  output logic [NumRules-1:0]           sbr_req_o,
  input  logic [NumRules-1:0]           sbr_gnt_i,
  output logic [AddrWidth-1:0]          sbr_addr_o,
  output logic                          sbr_we_o,
  output logic [DataWidth/8-1:0]        sbr_be_o,
  output logic [DataWidth-1:0]          sbr_wdata_o,
  output logic [IdWidth-1:0]            sbr_aid_o,
  input  logic [NumRules-1:0]           sbr_rvalid_i,
  input  logic [NumRules-1:0]           sbr_err_i,
  input  logic [NumRules*DataWidth-1:0] sbr_rdata_i,
  input  logic [NumRules*IdWidth-1:0]   sbr_rid_i,
  output logic                          busy_o,
  output logic                          proto_err_o
);

  localparam int unsigned SelW = $clog2(NumRules + 1);
  localparam int unsigned CntW = $clog2(MaxTrans + 1);

  logic [SelW-1:0] sel, last_sel_q;
  logic [CntW-1:0] cnt_q;
  logic            err_rvalid_q, proto_err_q;
  logic [IdWidth-1:0] err_rid_q;
  logic            stall, sel_gnt, hs;

  assign sbr_addr_o  = mgr_addr_i;
  assign sbr_we_o    = mgr_we_i;
  assign sbr_be_o    = mgr_be_i;
  assign sbr_wdata_o = mgr_wdata_i;
  assign sbr_aid_o   = mgr_aid_i;

  // Walk rules from highest to lowest so the lowest matching rule wins.
  always_comb begin
    sel = '0;
    for (int r = int'(NumRules) - 1; r >= 0; r--) begin
      if (mgr_addr_i >= RuleStart[r] && mgr_addr_i < RuleEnd[r]) begin
        sel = SelW'(RuleIdx[r]);
      end
    end
  end

  // Switching targets waits for the pipe to drain so responses stay in order.
  assign stall = ((cnt_q != '0) && (sel != last_sel_q)) || (cnt_q == CntW'(MaxTrans));

  always_comb begin
    sbr_req_o = '0;
    sel_gnt   = (sel == '0);
    for (int unsigned k = 0; k < NumRules; k++) begin
      if (sel == SelW'(k + 1)) begin
        sbr_req_o[k] = mgr_req_i & ~stall;
        sel_gnt      = sbr_gnt_i[k];
      end
    end
  end

  assign mgr_gnt_o = sel_gnt & mgr_req_i & ~stall;
  assign hs        = mgr_req_i & mgr_gnt_o;

  always_comb begin
    mgr_rvalid_o = err_rvalid_q;
    mgr_rdata_o  = ErrData;
    mgr_err_o    = 1'b1;
    mgr_rid_o    = err_rid_q;
    for (int unsigned k = 0; k < NumRules; k++) begin
      if (last_sel_q == SelW'(k + 1)) begin
        mgr_rvalid_o = sbr_rvalid_i[k];
        mgr_rdata_o  = sbr_rdata_i[k*DataWidth +: DataWidth];
        mgr_err_o    = sbr_err_i[k];
        mgr_rid_o    = sbr_rid_i[k*IdWidth +: IdWidth];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      last_sel_q   <= '0;
      err_rvalid_q <= 1'b0;
      err_rid_q    <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      err_rvalid_q <= hs && (sel == '0);
      if (hs && (sel == '0)) err_rid_q <= mgr_aid_i;
      if (hs) last_sel_q <= sel;
      if (hs && !mgr_rvalid_o) begin
        cnt_q <= cnt_q + CntW'(1);
      end else if (!hs && mgr_rvalid_o && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CntW'(1);
      end
      if (mgr_rvalid_o && (cnt_q == '0)) proto_err_q <= 1'b1;
    end
  end

  assign busy_o      = (cnt_q != '0);
  assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_user_addr_demux.sv
// Directed bench for user_addr_demux: decode table plus multi-cycle ordering/error sequences.
module tb_user_addr_demux;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mgr_req_i, mgr_we_i;
  logic [31:0] mgr_addr_i, mgr_wdata_i;
  logic [3:0]  mgr_be_i;
  logic        mgr_aid_i;
  logic [1:0]  sbr_gnt_i, sbr_rvalid_i, sbr_err_i, sbr_rid_i;
  logic [63:0] sbr_rdata_i;

  logic        mgr_gnt_o, mgr_rvalid_o, mgr_err_o, mgr_rid_o, busy_o, proto_err_o;
  logic [31:0] mgr_rdata_o, sbr_addr_o, sbr_wdata_o;
  logic [1:0]  sbr_req_o;
  logic        sbr_we_o, sbr_aid_o;
  logic [3:0]  sbr_be_o;

  // Second instance with overlapping rules mapped in reverse port order.
  logic        o_gnt, o_rvalid, o_err, o_rid, o_busy, o_perr, o_we, o_aid;
  logic [31:0] o_rdata, o_addr, o_wdata;
  logic [1:0]  o_req;
  logic [3:0]  o_be;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  user_addr_demux u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mgr_req_i(mgr_req_i), .mgr_gnt_o(mgr_gnt_o), .mgr_addr_i(mgr_addr_i),
    .mgr_we_i(mgr_we_i), .mgr_be_i(mgr_be_i), .mgr_wdata_i(mgr_wdata_i),
    .mgr_aid_i(mgr_aid_i), .mgr_rvalid_o(mgr_rvalid_o), .mgr_rdata_o(mgr_rdata_o),
    .mgr_err_o(mgr_err_o), .mgr_rid_o(mgr_rid_o), .sbr_req_o(sbr_req_o),
    .sbr_gnt_i(sbr_gnt_i), .sbr_addr_o(sbr_addr_o), .sbr_we_o(sbr_we_o),
    .sbr_be_o(sbr_be_o), .sbr_wdata_o(sbr_wdata_o), .sbr_aid_o(sbr_aid_o),
    .sbr_rvalid_i(sbr_rvalid_i), .sbr_err_i(sbr_err_i), .sbr_rdata_i(sbr_rdata_i),
    .sbr_rid_i(sbr_rid_i), .busy_o(busy_o), .proto_err_o(proto_err_o)
  );

  user_addr_demux #(
    .RuleStart('{32'h2000_0000, 32'h2000_0800}),
    .RuleEnd  ('{32'h2000_1000, 32'h2000_2000}),
    .RuleIdx  ('{2, 1})
  ) u_ovl (
    .clk_i(clk_i), .rst_i(rst_i),
    .mgr_req_i(mgr_req_i), .mgr_gnt_o(o_gnt), .mgr_addr_i(mgr_addr_i),
    .mgr_we_i(mgr_we_i), .mgr_be_i(mgr_be_i), .mgr_wdata_i(mgr_wdata_i),
    .mgr_aid_i(mgr_aid_i), .mgr_rvalid_o(o_rvalid), .mgr_rdata_o(o_rdata),
    .mgr_err_o(o_err), .mgr_rid_o(o_rid), .sbr_req_o(o_req),
    .sbr_gnt_i(sbr_gnt_i), .sbr_addr_o(o_addr), .sbr_we_o(o_we),
    .sbr_be_o(o_be), .sbr_wdata_o(o_wdata), .sbr_aid_o(o_aid),
    .sbr_rvalid_i(sbr_rvalid_i), .sbr_err_i(sbr_err_i), .sbr_rdata_i(sbr_rdata_i),
    .sbr_rid_i(sbr_rid_i), .busy_o(o_busy), .proto_err_o(o_perr)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  gnt;
    logic [1:0]  exp_req;
    logic        exp_gnt;
    logic [1:0]  exp_ovl;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    vecs[0] = '{32'h2000_0000, 2'b11, 2'b01, 1'b1, 2'b10};
    vecs[1] = '{32'h2000_0FFC, 2'b01, 2'b01, 1'b1, 2'b10};
    vecs[2] = '{32'h2000_1000, 2'b10, 2'b10, 1'b1, 2'b01};
    vecs[3] = '{32'h2000_1FFC, 2'b01, 2'b10, 1'b0, 2'b01};
    vecs[4] = '{32'h2000_2000, 2'b00, 2'b00, 1'b1, 2'b00};
    vecs[5] = '{32'h1FFF_FFFF, 2'b00, 2'b00, 1'b1, 2'b00};
    vecs[6] = '{32'h2000_1004, 2'b00, 2'b10, 1'b0, 2'b01};
    vecs[7] = '{32'h2000_0004, 2'b10, 2'b01, 1'b0, 2'b10};
    vecs[8] = '{32'h2000_0900, 2'b11, 2'b01, 1'b1, 2'b10};

    rst_i = 1'b1; mgr_req_i = 1'b0; mgr_we_i = 1'b0; mgr_addr_i = '0; mgr_wdata_i = '0;
    mgr_be_i = 4'hF; mgr_aid_i = 1'b0; sbr_gnt_i = '0; sbr_rvalid_i = '0; sbr_err_i = '0;
    sbr_rid_i = '0; sbr_rdata_i = '0;
    step(); step();
    rst_i = 1'b0;
    #1;
    check("reset_busy", busy_o, 0);
    check("reset_proto_err", proto_err_o, 0);
    check("reset_rvalid", mgr_rvalid_o, 0);

    // Decode/grant table with no outstanding transactions; req dropped before the edge.
    for (int i = 0; i < 9; i++) begin
      mgr_addr_i = vecs[i].addr;
      sbr_gnt_i  = vecs[i].gnt;
      mgr_req_i  = 1'b1;
      #1;
      check($sformatf("vec%0d_req", i), sbr_req_o, vecs[i].exp_req);
      check($sformatf("vec%0d_gnt", i), mgr_gnt_o, vecs[i].exp_gnt);
      check($sformatf("vec%0d_ovl_req", i), o_req, vecs[i].exp_ovl);
      check($sformatf("vec%0d_addr_thru", i), sbr_addr_o, vecs[i].addr);
      mgr_req_i = 1'b0;
      sbr_gnt_i = '0;
      step();
    end
    check("table_no_busy", busy_o, 0);

    // Read to port 2, response two cycles after the grant.
    mgr_req_i = 1'b1; mgr_addr_i = 32'h2000_1004; sbr_gnt_i = 2'b10;
    #1;
    check("p2_req", sbr_req_o, 2'b10);
    check("p2_gnt", mgr_gnt_o, 1);
    step();
    mgr_req_i = 1'b0; sbr_gnt_i = '0;
    #1;
    check("p2_busy", busy_o, 1);
    step();
    sbr_rvalid_i = 2'b10; sbr_rdata_i = {32'h0000_1234, 32'h0}; sbr_rid_i = 2'b10;
    #1;
    check("p2_rvalid", mgr_rvalid_o, 1);
    check("p2_rdata", mgr_rdata_o, 32'h1234);
    check("p2_err", mgr_err_o, 0);
    check("p2_rid", mgr_rid_o, 1);
    step();
    sbr_rvalid_i = '0; sbr_rid_i = '0;
    #1;
    check("p2_idle", busy_o, 0);

    // Unmapped read answered by the error subordinate.
    mgr_req_i = 1'b1; mgr_addr_i = 32'h4000_0000; mgr_aid_i = 1'b1;
    #1;
    check("err_gnt", mgr_gnt_o, 1);
    check("err_no_req", sbr_req_o, 2'b00);
    step();
    mgr_req_i = 1'b0; mgr_aid_i = 1'b0;
    #1;
    check("err_rvalid", mgr_rvalid_o, 1);
    check("err_err", mgr_err_o, 1);
    check("err_rdata", mgr_rdata_o, 32'hBADCAB1E);
    check("err_rid", mgr_rid_o, 1);
    step();
    #1;
    check("err_rvalid_off", mgr_rvalid_o, 0);
    check("err_idle", busy_o, 0);

    // Target switch blocks until port 1 drains.
    mgr_req_i = 1'b1; mgr_addr_i = 32'h2000_0000; sbr_gnt_i = 2'b01;
    step();
    mgr_addr_i = 32'h2000_1000; sbr_gnt_i = 2'b11;
    #1;
    check("sw_gnt_stall", mgr_gnt_o, 0);
    check("sw_req_stall", sbr_req_o, 2'b00);
    step();
    sbr_rvalid_i = 2'b01;
    #1;
    check("sw_gnt_stall2", mgr_gnt_o, 0);
    check("sw_p1_rvalid", mgr_rvalid_o, 1);
    step();
    sbr_rvalid_i = '0;
    #1;
    check("sw_req_go", sbr_req_o, 2'b10);
    check("sw_gnt_go", mgr_gnt_o, 1);
    step();
    mgr_req_i = 1'b0; sbr_gnt_i = '0; sbr_rvalid_i = 2'b10;
    step();
    sbr_rvalid_i = '0;
    #1;
    check("sw_idle", busy_o, 0);

    // MaxTrans limit and simultaneous handshake plus response.
    mgr_req_i = 1'b1; mgr_addr_i = 32'h2000_0000; sbr_gnt_i = 2'b01;
    step(); step();
    #1;
    check("max_gnt_stall", mgr_gnt_o, 0);
    check("max_req_stall", sbr_req_o, 2'b00);
    step();
    sbr_rvalid_i = 2'b01;
    #1;
    check("max_gnt_stall2", mgr_gnt_o, 0);
    step();
    #1;
    check("max_third_gnt", mgr_gnt_o, 1);
    step();
    mgr_req_i = 1'b0; sbr_gnt_i = '0; sbr_rvalid_i = '0;
    #1;
    check("max_busy_hold", busy_o, 1);
    sbr_rvalid_i = 2'b01;
    step();
    sbr_rvalid_i = '0;
    #1;
    check("max_drained", busy_o, 0);
    check("max_no_perr", proto_err_o, 0);

    // Stray response: sticky protocol error, counter stays at zero, reset clears.
    sbr_rvalid_i = 2'b01;
    #1;
    check("perr_before", proto_err_o, 0);
    step();
    sbr_rvalid_i = '0;
    #1;
    check("perr_set", proto_err_o, 1);
    check("perr_cnt0", busy_o, 0);
    step();
    #1;
    check("perr_sticky", proto_err_o, 1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #1;
    check("perr_cleared", proto_err_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_rvalid", mgr_rvalid_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
